// File: rtl/e203_dtcm_icb2sram_pkg.sv
// e203_dtcm_icb2sram_pkg: shared constants for the DTCM ICB-to-SRAM bridge
package e203_dtcm_icb2sram_pkg;

    localparam int E203_XLEN             = 32;
    localparam int E203_DTCM_ADDR_WIDTH  = 16;
    localparam int E203_DTCM_RSP_FIFO_DP = 2;

    // Response payload is {rdata, excl_ok, is_read}
    function automatic int rsp_width(input int dw);
        return dw + 2;
    endfunction

endpackage

// File: rtl/e203_dtcm_icb2sram_if.sv
// e203_dtcm_icb2sram_if: DTCM ICB command/response bundle between LSU and bridge
interface e203_dtcm_icb2sram_if import e203_dtcm_icb2sram_pkg::*; #(
    parameter int AW = E203_DTCM_ADDR_WIDTH,
    parameter int DW = E203_XLEN
) ();

    logic            icb_cmd_valid;
    logic            icb_cmd_ready;
    logic [AW-1:0]   icb_cmd_addr;
    logic            icb_cmd_read;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_cmd_lock;
    logic            icb_cmd_excl;
    logic [1:0]      icb_cmd_size;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready;
    logic            icb_rsp_err;
    logic            icb_rsp_excl_ok;
    logic [DW-1:0]   icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
               icb_cmd_lock, icb_cmd_excl, icb_cmd_size, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
               icb_cmd_lock, icb_cmd_excl, icb_cmd_size, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_excl_ok, icb_rsp_rdata
    );

endinterface

// File: rtl/e203_dtcm_icb2sram_fifo.sv
// sirv_gnrl_fifo: general small synchronous FIFO used as the DTCM response queue
module sirv_gnrl_fifo import e203_dtcm_icb2sram_pkg::*; #(
    parameter int CUT_READY = 0,
    parameter int MSKO      = 0,
    parameter int DP        = E203_DTCM_RSP_FIFO_DP,
    parameter int DW        = 34
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_vld_i,
    output logic                     i_rdy_o,
    input  logic [DW-1:0]            i_dat_i,
    output logic                     o_vld_o,
    input  logic                     o_rdy_i,
    output logic [DW-1:0]            o_dat_o,
    output logic [$clog2(DP+1)-1:0]  cnt_o
);

    localparam int PW = (DP > 1) ? $clog2(DP) : 1;
    localparam int CW = $clog2(DP + 1);

    logic [DW-1:0] mem_q [DP];
    logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, push, pop;

    assign full    = cnt_q == CW'(DP);
    assign o_vld_o = cnt_q != '0;
    // Without the cut, a full queue still accepts when the head leaves in the same cycle
    assign i_rdy_o = (CUT_READY != 0) ? ~full : (~full | o_rdy_i);
    assign push    = i_vld_i & i_rdy_o;
    assign pop     = o_vld_o & o_rdy_i;
    assign o_dat_o = (MSKO != 0) ? (mem_q[rptr_q] & {DW{o_vld_o}}) : mem_q[rptr_q];
    assign cnt_o   = cnt_q;

    // Wrapping pointers; a simultaneous push and pop leaves the occupancy unchanged
    always_comb begin
        wptr_d = push ? ((wptr_q == PW'(DP - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop  ? ((rptr_q == PW'(DP - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= i_dat_i;
    end

endmodule

// File: rtl/e203_dtcm_icb2sram.sv
// e203_dtcm_icb2sram: LSU DTCM ICB port to 1-cycle-latency single-port SRAM, with LR/SC monitor
module e203_dtcm_icb2sram import e203_dtcm_icb2sram_pkg::*; #(
    parameter int AW = E203_DTCM_ADDR_WIDTH,
    parameter int DW = E203_XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    e203_dtcm_icb2sram_if.slave   icb,
    output logic                  ram_cs_o,
    output logic                  ram_we_o,
    output logic [AW-3:0]         ram_addr_o,
    output logic [DW/8-1:0]       ram_wem_o,
    output logic [DW-1:0]         ram_din_o,
    input  logic [DW-1:0]         ram_dout_i,
    output logic                  dtcm_active_o
);

    localparam int RW = rsp_width(DW);
    localparam int CW = $clog2(E203_DTCM_RSP_FIFO_DP + 1);

    logic          cmd_hsk, resv_hit, sc_fail, cmd_excl_ok, lr_set, resv_kill;
    logic          inf_vld_q, inf_read_q, inf_excl_ok_q;
    logic          resv_vld_q, resv_vld_d;
    logic [AW-3:0] resv_addr_q, resv_addr_d;
    logic          fifo_push, fifo_empty, fifo_o_vld, fifo_i_rdy;
    logic [CW-1:0] fifo_cnt;
    logic [RW-1:0] inf_rsp, fifo_head, rsp;
    logic          unused_ok;

    // Credit: every accepted command owns a slot until its response handshakes
    assign icb.icb_cmd_ready = (fifo_cnt + CW'(inf_vld_q)) < CW'(E203_DTCM_RSP_FIFO_DP);
    assign cmd_hsk           = icb.icb_cmd_valid & icb.icb_cmd_ready;

    assign resv_hit    = resv_vld_q & (resv_addr_q == icb.icb_cmd_addr[AW-1:2]);
    assign sc_fail     = icb.icb_cmd_excl & ~icb.icb_cmd_read & ~resv_hit;
    assign cmd_excl_ok = icb.icb_cmd_excl & (icb.icb_cmd_read | resv_hit);
    assign lr_set      = cmd_hsk & icb.icb_cmd_read & icb.icb_cmd_excl;
    // Any SC, and any plain store to the reserved word, ends the reservation
    assign resv_kill   = cmd_hsk & ~icb.icb_cmd_read & (icb.icb_cmd_excl | resv_hit);

    assign ram_cs_o   = cmd_hsk;
    assign ram_we_o   = cmd_hsk & ~icb.icb_cmd_read & ~sc_fail;
    assign ram_wem_o  = icb.icb_cmd_wmask & {(DW/8){ram_we_o}};
    assign ram_addr_o = icb.icb_cmd_addr[AW-1:2];
    assign ram_din_o  = icb.icb_cmd_wdata;

    // Reservation next state: LR arms it on its word, killing writes disarm it
    always_comb begin
        resv_vld_d  = lr_set ? 1'b1 : (resv_kill ? 1'b0 : resv_vld_q);
        resv_addr_d = lr_set ? ram_addr_o : resv_addr_q;
    end

    // In-flight slot tracks the command whose SRAM data appears this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inf_vld_q     <= 1'b0;
            inf_read_q    <= 1'b0;
            inf_excl_ok_q <= 1'b0;
            resv_vld_q    <= 1'b0;
            resv_addr_q   <= '0;
        end else begin
            inf_vld_q     <= cmd_hsk;
            inf_read_q    <= cmd_hsk ? icb.icb_cmd_read : inf_read_q;
            inf_excl_ok_q <= cmd_hsk ? cmd_excl_ok : inf_excl_ok_q;
            resv_vld_q    <= resv_vld_d;
            resv_addr_q   <= resv_addr_d;
        end
    end

    assign inf_rsp    = {ram_dout_i & {DW{inf_read_q}}, inf_excl_ok_q, inf_read_q};
    assign fifo_empty = ~fifo_o_vld;
    // The in-flight response is parked whenever it cannot leave by flow-through now
    assign fifo_push  = inf_vld_q & ~(fifo_empty & icb.icb_rsp_ready);

    sirv_gnrl_fifo #(
        .CUT_READY (0),
        .MSKO      (0),
        .DP        (E203_DTCM_RSP_FIFO_DP),
        .DW        (RW)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld_i (fifo_push),
        .i_rdy_o (fifo_i_rdy),
        .i_dat_i (inf_rsp),
        .o_vld_o (fifo_o_vld),
        .o_rdy_i (icb.icb_rsp_ready),
        .o_dat_o (fifo_head),
        .cnt_o   (fifo_cnt)
    );

    assign rsp                 = fifo_empty ? inf_rsp : fifo_head;
    assign icb.icb_rsp_valid   = ~fifo_empty | inf_vld_q;
    assign icb.icb_rsp_rdata   = rsp[RW-1:2];
    assign icb.icb_rsp_excl_ok = rsp[1];
    assign icb.icb_rsp_err     = 1'b0;
    assign dtcm_active_o       = icb.icb_cmd_valid | inf_vld_q | ~fifo_empty;

    assign unused_ok = ^{icb.icb_cmd_lock, icb.icb_cmd_size, icb.icb_cmd_addr[1:0], rsp[0], fifo_i_rdy};

endmodule

// File: tb/tb_e203_dtcm_icb2sram.sv
// tb_e203_dtcm_icb2sram: directed and randomized checks of the DTCM bridge against a queue model
module tb_e203_dtcm_icb2sram;

    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    e203_dtcm_icb2sram_if #(.AW(AW), .DW(DW)) icb ();

    logic          ram_cs, ram_we, dtcm_active;
    logic [AW-3:0] ram_addr;
    logic [3:0]    ram_wem;
    logic [31:0]   ram_din, ram_dout;

    e203_dtcm_icb2sram #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb           (icb),
        .ram_cs_o      (ram_cs),
        .ram_we_o      (ram_we),
        .ram_addr_o    (ram_addr),
        .ram_wem_o     (ram_wem),
        .ram_din_o     (ram_din),
        .ram_dout_i    (ram_dout),
        .dtcm_active_o (dtcm_active)
    );

    // SRAM macro: 1-cycle read latency, garbage on dout when not reading
    logic [31:0] sram [0:(1<<(AW-2))-1];
    always @(posedge clk) begin
        if (ram_cs && ram_we)
            for (int b = 0; b < 4; b++) if (ram_wem[b]) sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= (ram_cs && !ram_we) ? sram[ram_addr] : $urandom;
    end

    typedef struct { logic [31:0] rdata; logic ok; } rsp_t;
    rsp_t        mq[$];
    logic [31:0] dut_log[$];
    logic [31:0] ref_mem [0:15];
    logic        resv_v = 1'b0;
    logic [AW-3:0] resv_a = '0;
    logic        hsk_seen = 1'b0;
    int          n_total = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: outstanding responses as a queue, memory as an array, one reservation
    always @(negedge clk) begin : model
        logic exp_rdy, exp_vld, hsk, hit, wr_ok;
        logic [3:0] w;
        rsp_t r;
        if (!rst_n) begin
            mq.delete();
            resv_v = 1'b0;
        end
        exp_rdy  = mq.size() < 2;
        exp_vld  = mq.size() != 0;
        hsk      = icb.icb_cmd_valid && exp_rdy;
        hsk_seen = icb.icb_cmd_valid && icb.icb_cmd_ready;
        w        = icb.icb_cmd_addr[5:2];
        hit      = resv_v && (resv_a == icb.icb_cmd_addr[AW-1:2]);
        wr_ok    = hsk && !icb.icb_cmd_read && (!icb.icb_cmd_excl || hit);
        chk("cmd_ready", icb.icb_cmd_ready, exp_rdy);
        chk("rsp_valid", icb.icb_rsp_valid, exp_vld);
        if (exp_vld) begin
            chk("rsp_rdata", icb.icb_rsp_rdata, mq[0].rdata);
            chk("rsp_excl_ok", icb.icb_rsp_excl_ok, mq[0].ok);
            chk("rsp_err", icb.icb_rsp_err, 0);
        end
        chk("ram_cs", ram_cs, hsk);
        chk("ram_we", ram_we, wr_ok);
        chk("ram_wem", ram_wem, wr_ok ? icb.icb_cmd_wmask : 4'b0);
        if (hsk) chk("ram_addr", ram_addr, icb.icb_cmd_addr[AW-1:2]);
        if (wr_ok) chk("ram_din", ram_din, icb.icb_cmd_wdata);
        chk("dtcm_active", dtcm_active, icb.icb_cmd_valid || exp_vld);
        if (icb.icb_rsp_valid && icb.icb_rsp_ready) dut_log.push_back(icb.icb_rsp_rdata);
        if (exp_vld && icb.icb_rsp_ready) void'(mq.pop_front());
        if (hsk) begin
            r.rdata = icb.icb_cmd_read ? ref_mem[w] : 32'h0;
            r.ok    = icb.icb_cmd_excl && (icb.icb_cmd_read || hit);
            if (wr_ok)
                for (int b = 0; b < 4; b++) if (icb.icb_cmd_wmask[b]) ref_mem[w][8*b +: 8] = icb.icb_cmd_wdata[8*b +: 8];
            if (icb.icb_cmd_read && icb.icb_cmd_excl) begin
                resv_v = 1'b1;
                resv_a = icb.icb_cmd_addr[AW-1:2];
            end else if (!icb.icb_cmd_read && (icb.icb_cmd_excl || hit)) resv_v = 1'b0;
            mq.push_back(r);
        end
    end

    task automatic drive(input logic rd, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m, input logic ex);
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_wdata = d;
        icb.icb_cmd_wmask = m;
        icb.icb_cmd_excl  = ex;
        icb.icb_cmd_lock  = ex;
        icb.icb_cmd_size  = 2'b10;
    endtask

    task automatic send(input logic rd, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m, input logic ex, output logic we);
        int n = 0;
        drive(rd, a, d, m, ex);
        do begin
            @(negedge clk);
            n++;
        end while (!icb.icb_cmd_ready && n < 50);
        chk("cmd_accept", icb.icb_cmd_ready, 1);
        we = ram_we;
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b0;
    endtask

    task automatic xfer(input logic rd, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m, input logic ex,
                        output logic [31:0] rdata, output logic ok, output logic we);
        send(rd, a, d, m, ex, we);
        @(negedge clk);
        chk("rsp_latency", icb.icb_rsp_valid, 1);
        chk("rsp_err_const", icb.icb_rsp_err, 0);
        rdata = icb.icb_rsp_rdata;
        ok    = icb.icb_rsp_excl_ok;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] d;
        logic ok, we;
        logic [AW-1:0] a;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            sram[i] = d;
            ref_mem[i] = d;
        end
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_cmd_excl  = 1'b0;
        icb.icb_cmd_lock  = 1'b0;
        icb.icb_cmd_size  = 2'b10;
        icb.icb_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", icb.icb_cmd_ready, 1);
        chk("rst_rsp_valid", icb.icb_rsp_valid, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_excl_ok", icb.icb_rsp_excl_ok, 0);
        chk("rst_rdata", icb.icb_rsp_rdata, 0);
        chk("rst_active", dtcm_active, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, 16'h10, 32'hA5A5_1234, 4'hF, 0, d, ok, we);
        chk("wr_we", we, 1);
        xfer(1, 16'h10, 0, 0, 0, d, ok, we);
        chk("single_read", d, 32'hA5A5_1234);

        xfer(0, 16'h14, 32'h1122_3344, 4'hF, 0, d, ok, we);
        xfer(0, 16'h14, 32'h0000_BB00, 4'b0010, 0, d, ok, we);
        chk("byte_wr_rdata0", d, 0);
        xfer(1, 16'h14, 0, 0, 0, d, ok, we);
        chk("byte_write", d, 32'h1122_BB44);

        xfer(1, 16'h20, 0, 0, 1, d, ok, we);
        chk("lr_ok", ok, 1);
        xfer(0, 16'h20, 32'd7, 4'hF, 1, d, ok, we);
        chk("sc_pass_ok", ok, 1);
        chk("sc_pass_we", we, 1);
        xfer(1, 16'h20, 0, 0, 0, d, ok, we);
        chk("sc_pass_mem", d, 7);
        xfer(0, 16'h20, 32'd9, 4'hF, 1, d, ok, we);
        chk("sc_again_ok", ok, 0);
        xfer(1, 16'h20, 0, 0, 0, d, ok, we);
        chk("sc_again_mem", d, 7);

        xfer(1, 16'h20, 0, 0, 1, d, ok, we);
        xfer(0, 16'h20, 32'd5, 4'hF, 0, d, ok, we);
        chk("plain_st_ok", ok, 0);
        xfer(0, 16'h20, 32'd8, 4'hF, 1, d, ok, we);
        chk("sc_kill_ok", ok, 0);
        chk("sc_kill_we", we, 0);
        xfer(1, 16'h20, 0, 0, 0, d, ok, we);
        chk("sc_kill_mem", d, 5);

        xfer(0, 16'h0, 32'h1111_1111, 4'hF, 0, d, ok, we);
        xfer(0, 16'h4, 32'h2222_2222, 4'hF, 0, d, ok, we);
        xfer(0, 16'h8, 32'h3333_3333, 4'hF, 0, d, ok, we);
        dut_log.delete();
        icb.icb_rsp_ready = 1'b0;
        fork
            begin
                logic w0;
                send(1, 16'h0, 0, 0, 0, w0);
                send(1, 16'h4, 0, 0, 0, w0);
                send(1, 16'h8, 0, 0, 0, w0);
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_cmd_ready", icb.icb_cmd_ready, 0);
                chk("bp_rsp_valid", icb.icb_rsp_valid, 1);
                @(posedge clk);
                #1;
                icb.icb_rsp_ready = 1'b1;
            end
        join
        for (int i = 0; i < 50 && dut_log.size() < 3; i++) @(negedge clk);
        chk("bp_count", dut_log.size(), 3);
        if (dut_log.size() >= 3) begin
            chk("bp_rsp0", dut_log[0], 32'h1111_1111);
            chk("bp_rsp1", dut_log[1], 32'h2222_2222);
            chk("bp_rsp2", dut_log[2], 32'h3333_3333);
        end
        @(posedge clk);
        #1;

        xfer(1, 16'h20, 0, 0, 1, d, ok, we);
        icb.icb_rsp_ready = 1'b0;
        send(1, 16'h0, 0, 0, 0, we);
        send(1, 16'h4, 0, 0, 0, we);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", icb.icb_rsp_valid, 0);
        chk("midrst_cmd_ready", icb.icb_cmd_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        icb.icb_rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_stale", icb.icb_rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        xfer(0, 16'h20, 32'h55, 4'hF, 1, d, ok, we);
        chk("midrst_resv_lost", ok, 0);
        xfer(1, 16'h20, 0, 0, 0, d, ok, we);
        chk("midrst_mem_kept", d, 5);

        for (int c = 0; c < 3000; c++) begin
            if (!icb.icb_cmd_valid || hsk_seen) begin
                if ($urandom_range(0, 9) < 6) begin
                    logic ex;
                    ex = $urandom_range(0, 9) < 3;
                    a = '0;
                    a[5:2] = 4'($urandom_range(0, ex ? 3 : 15));
                    a[1:0] = 2'($urandom);
                    drive(1'($urandom), a, $urandom, 4'($urandom), ex);
                end else icb.icb_cmd_valid = 1'b0;
            end
            icb.icb_rsp_ready = $urandom_range(0, 9) < 7;
            @(posedge clk);
            #1;
        end
        icb.icb_cmd_valid = 1'b0;
        icb.icb_rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
